regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port among NUM_REQ writeback sources: 0 = ALU, 1 = load/memory, 2 = mul/div.
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the granted write onto the register file's write-enable, destination and data inputs.
- Keeps a pending-write scoreboard (busy mask) that decode uses to stall on RAW hazards; sits between the writeback stage and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: requester slots and the hardwired zero register.
package regfile_write_arbiter_pkg;
    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_MDU  = 2;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps; the first set request wins.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among writeback sources (round-robin) and tracks
// outstanding destination registers in a busy mask used by decode for RAW stalls.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_dest,
    output logic [2**ADDR_W-1:0]      busy,
    output logic                      reg_write_enable,
    output logic [ADDR_W-1:0]         field_reg_dest,
    output logic [DATA_W-1:0]         reg_input_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG  = 2**ADDR_W;

    logic [IDX_W-1:0]   ptr_p0;
    logic [NUM_REQ-1:0] grant_p0;
    logic [IDX_W-1:0]   grant_idx_p0;
    logic               found_p0;
    logic               transfer_p0;
    logic [ADDR_W-1:0]  sel_dest_p0;
    logic [DATA_W-1:0]  sel_data_p0;
    logic [NREG-1:0]    busy_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_p0),
        .grant     (grant_p0),
        .grant_idx (grant_idx_p0),
        .found     (found_p0)
    );

    assign req_ready   = reset ? grant_p0 : '0;
    assign transfer_p0 = reset & found_p0;

    always_comb begin
        sel_dest_p0 = '0;
        sel_data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_p0[i]) begin
                sel_dest_p0 = req_dest[i*ADDR_W +: ADDR_W];
                sel_data_p0 = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_p0 <= '0;
        end else if (transfer_p0) begin
            ptr_p0 <= (grant_idx_p0 == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_p0 + 1'b1;
        end
    end

    // A new claim outranks a retiring write to the same register: the newer producer is still pending.
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NREG; r++) begin
            if (claim_valid && claim_dest == ADDR_W'(r)) begin
                busy_next[r] = 1'b1;
            end else if (transfer_p0 && sel_dest_p0 == ADDR_W'(r)) begin
                busy_next[r] = 1'b0;
            end
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // ---- stage p1: registered write port toward the register file ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_enable <= 1'b0;
            field_reg_dest   <= '0;
            reg_input_data   <= '0;
        end else begin
            reg_write_enable <= transfer_p0 && (sel_dest_p0 != ADDR_W'(REG_ZERO));
            if (transfer_p0) begin
                field_reg_dest <= sel_dest_p0;
                reg_input_data <= sel_data_p0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios followed by random traffic.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NREG    = 2**ADDR_W;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_dest = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      claim_valid = 1'b0;
    logic [ADDR_W-1:0]         claim_dest = '0;
    logic [NREG-1:0]           busy;
    logic                      reg_write_enable;
    logic [ADDR_W-1:0]         field_reg_dest;
    logic [DATA_W-1:0]         reg_input_data;

    regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_dest         (req_dest),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .claim_valid      (claim_valid),
        .claim_dest       (claim_dest),
        .busy             (busy),
        .reg_write_enable (reg_write_enable),
        .field_reg_dest   (field_reg_dest),
        .reg_input_data   (reg_input_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               expq[$];
    int                checks = 0;
    int                errors = 0;
    int                m_ptr = 0;
    logic [NREG-1:0]   m_busy = '0;
    logic [ADDR_W-1:0] m_dest = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit                mon_on = 1'b0;
    int                last_grant = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // One clock of stimulus; the model derives ready and next state from the rules directly.
    task automatic step(input logic rst_n, input logic [NUM_REQ-1:0] v,
                        input logic [NUM_REQ*ADDR_W-1:0] d, input logic [NUM_REQ*DATA_W-1:0] x,
                        input logic cv, input logic [ADDR_W-1:0] cd);
        int                g;
        logic [NUM_REQ-1:0] exp_ready;
        logic [NREG-1:0]    nb;
        logic [ADDR_W-1:0]  gd;
        logic [DATA_W-1:0]  gx;
        @(negedge clk);
        reset = rst_n; req_valid = v; req_dest = d; req_data = x;
        claim_valid = cv; claim_dest = cd;
        #1;
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        last_grant = g;
        nb = m_busy; gd = '0; gx = '0;
        if (g >= 0) begin
            gd = d[g*ADDR_W +: ADDR_W];
            gx = x[g*DATA_W +: DATA_W];
            nb[gd] = 1'b0;
        end
        if (cv && cd != 0) nb[cd] = 1'b1;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy = '0; m_ptr = 0; m_dest = '0; m_data = '0;
            expq.delete();
        end else begin
            m_busy = nb;
            if (g >= 0) begin
                m_ptr = (g + 1) % NUM_REQ;
                m_dest = gd; m_data = gx;
                if (gd != 0) expq.push_back('{dest: gd, data: gx});
            end
        end
    endtask

    // Monitor: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            wr_t e;
            if (reg_write_enable) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: got dest %0d data %0h, expected no write",
                             field_reg_dest, reg_input_data);
                end else begin
                    e = expq.pop_front();
                    check("write_dest", 64'(field_reg_dest), 64'(e.dest));
                    check("write_data", 64'(reg_input_data), 64'(e.data));
                end
            end
            check("busy", 64'(busy), 64'(m_busy));
            check("held_dest", 64'(field_reg_dest), 64'(m_dest));
            check("held_data", 64'(reg_input_data), 64'(m_data));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [NUM_REQ*ADDR_W-1:0] pack_d(input int a, input int b, input int c);
        logic [NUM_REQ*ADDR_W-1:0] r;
        r = '0;
        r[REQ_ALU*ADDR_W +: ADDR_W] = ADDR_W'(a);
        r[REQ_MEM*ADDR_W +: ADDR_W] = ADDR_W'(b);
        r[REQ_MDU*ADDR_W +: ADDR_W] = ADDR_W'(c);
        return r;
    endfunction

    function automatic logic [NUM_REQ*DATA_W-1:0] pack_x(input logic [31:0] a, input logic [31:0] b,
                                                         input logic [31:0] c);
        return {c, b, a};
    endfunction

    initial begin
        logic [NUM_REQ*ADDR_W-1:0] pd;
        logic [NUM_REQ*DATA_W-1:0] px;
        logic [NUM_REQ-1:0]        pv;
        int                        rr_dest[6];

        // Reset with all requesters valid.
        step(1'b0, 3'b111, pack_d(1, 2, 3), pack_x(1, 2, 3), 1'b0, '0);
        mon_on = 1'b1;
        step(1'b0, 3'b111, pack_d(1, 2, 3), pack_x(1, 2, 3), 1'b1, 5'd4);
        check("reset_we", 64'(reg_write_enable), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Single write from the memory requester.
        step(1'b1, 3'b010, pack_d(0, 5, 0), pack_x(0, 32'hDEADBEEF, 0), 1'b0, '0);
        check("single_we", 64'(reg_write_enable), 64'd1);
        check("single_dest", 64'(field_reg_dest), 64'd5);
        check("single_data", 64'(reg_input_data), 64'hDEADBEEF);
        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        check("single_we_drop", 64'(reg_write_enable), 64'd0);

        // Round-robin from pointer 0 with everyone valid.
        step(1'b0, 3'b000, '0, '0, 1'b0, '0);
        rr_dest = '{1, 2, 3, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'b111, pack_d(1, 2, 3), pack_x(32'hA0, 32'hB0, 32'hC0), 1'b0, '0);
            check("rr_dest", 64'(field_reg_dest), 64'(rr_dest[i]));
        end

        // r0 write and r0 claim are both inert; pointer is 0 here, so ALU wins.
        step(1'b1, 3'b001, pack_d(0, 0, 0), pack_x(32'h1234, 0, 0), 1'b1, 5'd0);
        check("r0_we", 64'(reg_write_enable), 64'd0);
        check("r0_busy", 64'(busy[0]), 64'd0);

        // Scoreboard set, clear, and claim-beats-clear.
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd7);
        check("claim7", 64'(busy[7]), 64'd1);
        step(1'b1, 3'b100, pack_d(0, 0, 7), pack_x(0, 0, 32'h77), 1'b0, '0);
        check("clear7", 64'(busy[7]), 64'd0);
        step(1'b1, 3'b001, pack_d(9, 0, 0), pack_x(32'h99, 0, 0), 1'b1, 5'd9);
        check("claim_wins9", 64'(busy[9]), 64'd1);

        // Build busy = 0x0F0E, then reset with three requesters pending.
        foreach (rr_dest[i]) rr_dest[i] = 0;
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd1);
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd2);
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd3);
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd8);
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd10);
        step(1'b1, 3'b000, '0, '0, 1'b1, 5'd11);
        check("busy_f0e", 64'(busy), 64'h0F0E);
        step(1'b1, 3'b010, pack_d(0, 12, 0), pack_x(0, 32'h5, 0), 1'b0, '0);
        step(1'b0, 3'b111, pack_d(13, 14, 15), pack_x(32'h13, 32'h14, 32'h15), 1'b0, '0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_we", 64'(reg_write_enable), 64'd0);
        step(1'b1, 3'b111, pack_d(13, 14, 15), pack_x(32'h13, 32'h14, 32'h15), 1'b0, '0);
        check("post_reset_grant", 64'(last_grant), 64'd0);

        // Random traffic: a requester holds valid/dest/data until granted.
        pv = 3'b110; pd = pack_d(13, 14, 15); px = pack_x(32'h13, 32'h14, 32'h15);
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 60) begin
                    pv[i] = 1'b1;
                    pd[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, NREG - 1));
                    px[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            step(1'b1, pv, pd, px, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREG - 1)));
            if (last_grant >= 0) pv[last_grant] = 1'b0;
        end

        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        step(1'b1, 3'b000, '0, '0, 1'b0, '0);
        check("queue_drained", 64'(expq.size()), 64'd0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
